light_seg_scan: RTL and testbench
=================================

LIGHT_SEG_SCAN -- requirements
Module: light_seg_scan

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of multiplexed light channels and digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is displayed (legal minimum 2).
REQ-003 SHALL have parameter BLINK_DIV, default 64, meaning complete scan frames per blink half-period (legal minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register uses its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port light, input, 2*NUM_CH bits: channel k light code at bits [2k+1:2k].
REQ-007 SHALL have port blink_en, input, NUM_CH bits: per-channel blink enable.
REQ-008 SHALL have port seg, output, 7 bits: registered active-low segment pattern.
REQ-009 SHALL have port an, output, NUM_CH bits: registered active-low digit enable, at most one bit low.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each scan frame.

Function
REQ-011 SHALL decode light codes as follows: 00 -> 0000001, 01 -> 0010000, 10 -> 0001000, 11 -> 1011000; blank is 1111111.
REQ-012 SHALL run a prescaler that counts 0..REFRESH_DIV-1, wraps to 0, and asserts internal tick in the cycle it holds REFRESH_DIV-1.
REQ-013 SHALL advance the digit index 0..NUM_CH-1 by one on each tick, wrapping from NUM_CH-1 to 0.
REQ-014 SHALL, on the tick where the index wraps, pulse frame_done high for exactly one cycle and capture light and blink_en into snapshot registers.
REQ-015 SHALL take the displayed values from the snapshot only, so a light change mid-frame appears from the next frame onward.
REQ-016 SHALL, on the clock edge following each tick, update an so that only bit [new index] is low, and update seg to the pattern of the matching snapshot channel. Both outputs SHALL change on the same edge.
REQ-017 SHALL run a frame counter 0..BLINK_DIV-1, advanced on frame_done and wrapping to 0; each wrap toggles blink_phase.
REQ-018 SHALL drive seg to blank for a digit when its snapshot blink_en bit is 1 and blink_phase is 1; an is unaffected.
REQ-019 SHALL, when NUM_CH=1, keep an[0] low after the first tick and assert frame_done on every tick.
REQ-020 SHALL size counters with ceil(log2) widths (minimum 1 bit) and never let any counter exceed its terminal value.

Reset
REQ-021 SHALL, while rst is high, force prescaler=0, digit index=NUM_CH-1, frame counter=0, blink_phase=0, light snapshot=all 00, blink_en snapshot=0, seg=1111111, an=all ones, and frame_done=0.
REQ-022 SHALL keep outputs blank until the first tick after reset release; that tick moves the index to 0 and is not a frame wrap, so no frame_done occurs.
REQ-023 SHALL, if rst asserts mid-digit or mid-frame, return immediately to the REQ-021 values without completing the current digit.

Structure
REQ-024 SHALL place the light code constants, the four segment patterns, and SEG_BLANK in shared package light_seg_pkg.
REQ-025 SHALL instantiate a combinational sub-module light_seg_decode (2-bit code in, 7-bit pattern out) for pattern lookup.

Verification
REQ-026 SHALL cover reset blanking and the first tick: NUM_CH=4, REFRESH_DIV=4; release rst -> seg=1111111 and an=1111 for 4 cycles, then an=1110 with no frame_done.
REQ-027 SHALL cover scan order and decoding: light=8'b11_10_01_00 with the snapshot loaded -> an cycles through 1110, 1101, 1011, 0111 with seg 0000001, 0010000, 0001000, 1011000, each held 4 cycles.
REQ-028 SHALL cover the mid-frame update: change light while an=1101 -> no seg change until after the next frame_done.
REQ-029 SHALL cover blinking: BLINK_DIV=2, blink_en=4'b0100 -> digit 2 shows 0001000 for 2 frames, then 1111111 for 2 frames, repeating; other digits never blank.
REQ-030 SHALL cover reset mid-scan: assert rst while an=1011 -> an=1111, seg=1111111, and frame_done=0 immediately, asynchronously, without waiting for a clk edge.
REQ-031 SHALL cover the single-channel case: NUM_CH=1, REFRESH_DIV=3 -> frame_done pulses every 3 cycles after the first tick, and an stays 0.

Source files
------------

// File: rtl/light_seg_pkg.sv
// light_seg_pkg: light code constants, active-low segment patterns and blank pattern
package light_seg_pkg;
  localparam logic [1:0] LIGHT_C0 = 2'b00;
  localparam logic [1:0] LIGHT_C1 = 2'b01;
  localparam logic [1:0] LIGHT_C2 = 2'b10;
  localparam logic [1:0] LIGHT_C3 = 2'b11;
  localparam logic [6:0] SEG_C0 = 7'b0000001;
  localparam logic [6:0] SEG_C1 = 7'b0010000;
  localparam logic [6:0] SEG_C2 = 7'b0001000;
  localparam logic [6:0] SEG_C3 = 7'b1011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/light_seg_decode.sv
// light_seg_decode: 2-bit light code (code) to 7-bit active-low segment pattern (pat)
module light_seg_decode
  import light_seg_pkg::*;
(
  input  logic [1:0] code,
  output logic [6:0] pat
);
  always_comb
    pat = code == LIGHT_C0 ? SEG_C0 :
          code == LIGHT_C1 ? SEG_C1 :
          code == LIGHT_C2 ? SEG_C2 : SEG_C3;
endmodule

// File: rtl/light_seg_scan.sv
// light_seg_scan: multiplexed light-code display scanner; in clk, rst, light, blink_en; out seg, an, frame_done
module light_seg_scan
  import light_seg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NUM_CH-1:0]   light,
  input  logic [NUM_CH-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic [NUM_CH-1:0]     an,
  output logic                  frame_done
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, ni;
  logic [FW-1:0] fcnt;
  logic run, phase, nphase, tick, wrap;
  logic [2*NUM_CH-1:0] snap_l, nl;
  logic [NUM_CH-1:0] snap_b, nb;
  logic [1:0] code;
  logic [6:0] pat;
  light_seg_decode u_dec (.code(code), .pat(pat));
  // run gates the very first tick after reset, which only moves the index to 0.
  // On a wrap edge the snapshot is loaded in the same edge that shows digit 0,
  // so the incoming light/blink/phase values feed the display directly.
  always_comb begin
    tick = presc == PW'(REFRESH_DIV - 1);
    wrap = tick && run && idx == IW'(NUM_CH - 1);
    ni = idx == IW'(NUM_CH - 1) ? '0 : idx + IW'(1);
    nl = wrap ? light : snap_l;
    nb = wrap ? blink_en : snap_b;
    nphase = (wrap && fcnt == FW'(BLINK_DIV - 1)) ? ~phase : phase;
    code = nl[{ni, 1'b0} +: 2];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx <= IW'(NUM_CH - 1);
      fcnt <= '0;
      run <= 1'b0;
      phase <= 1'b0;
      snap_l <= '0;
      snap_b <= '0;
      seg <= SEG_BLANK;
      an <= '1;
      frame_done <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      frame_done <= wrap;
      if (wrap) begin
        snap_l <= light;
        snap_b <= blink_en;
        fcnt <= fcnt == FW'(BLINK_DIV - 1) ? '0 : fcnt + FW'(1);
        phase <= nphase;
      end
      if (tick) begin
        run <= 1'b1;
        idx <= ni;
        an <= ~(NUM_CH'(1) << ni);
        seg <= (nb[ni] && nphase) ? SEG_BLANK : pat;
      end
    end
  end
endmodule

// File: tb/tb_light_seg_scan.sv
// tb_light_seg_scan: directed self-checking bench for light_seg_scan (4-channel and 1-channel instances)
module tb_light_seg_scan;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] light;
  logic [3:0] blink_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_done;
  logic [1:0] light1;
  logic blink1;
  logic [6:0] seg1;
  logic an1;
  logic fd1;
  int checks = 0;
  int fails = 0;
  logic [7:0] old_l;
  logic [3:0] ea;
  logic [6:0] es;

  always #5 clk = ~clk;

  light_seg_scan #(.NUM_CH(4), .REFRESH_DIV(4), .BLINK_DIV(2)) u4 (
    .clk(clk), .rst(rst), .light(light), .blink_en(blink_en),
    .seg(seg), .an(an), .frame_done(frame_done));

  light_seg_scan #(.NUM_CH(1), .REFRESH_DIV(3), .BLINK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .light(light1), .blink_en(blink1),
    .seg(seg1), .an(an1), .frame_done(fd1));

  function automatic logic [6:0] seg_of(input logic [1:0] c);
    case (c)
      2'b00: seg_of = 7'b0000001;
      2'b01: seg_of = 7'b0010000;
      2'b10: seg_of = 7'b0001000;
      default: seg_of = 7'b1011000;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got %b want 1111111", seg); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if (an1 !== 1'b1) begin fails++; $display("FAIL reset_an1 got %b want 1", an1); end
    checks++; if (seg1 !== 7'b1111111) begin fails++; $display("FAIL reset_seg1 got %b want 1111111", seg1); end
    checks++; if (fd1 !== 1'b0) begin fails++; $display("FAIL reset_fd1 got %b want 0", fd1); end
    rst = 1'b0;
  endtask

  task automatic test_first_tick;
    light = 8'b11_10_01_00;
    blink_en = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      checks++; if (an !== 4'b1111) begin fails++; $display("FAIL blank_an cyc %0d got %b want 1111", i, an); end
      checks++; if (seg !== 7'b1111111) begin fails++; $display("FAIL blank_seg cyc %0d got %b want 1111111", i, seg); end
    end
    cyc(1);
    checks++; if (an !== 4'b1110) begin fails++; $display("FAIL first_tick_an got %b want 1110", an); end
    checks++; if (seg !== 7'b0000001) begin fails++; $display("FAIL first_tick_seg got %b want 0000001", seg); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL first_tick_fd got %b want 0", frame_done); end
    for (int i = 5; i <= 19; i++) begin
      cyc(1);
      checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL frame0_fd cyc %0d got %b want 0", i, frame_done); end
    end
  endtask

  task automatic test_scan;
    cyc(1);
    old_l = 8'b11_10_01_00;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        ea = ~(4'b0001 << k);
        es = seg_of(old_l[2*k +: 2]);
        checks++; if (an !== ea) begin fails++; $display("FAIL scan_an d%0d c%0d got %b want %b", k, c, an, ea); end
        checks++; if (seg !== es) begin fails++; $display("FAIL scan_seg d%0d c%0d got %b want %b", k, c, seg, es); end
        checks++; if (frame_done !== (k == 0 && c == 0)) begin fails++; $display("FAIL scan_fd d%0d c%0d got %b", k, c, frame_done); end
        cyc(1);
      end
  endtask

  task automatic test_mid_frame;
    cyc(4);
    checks++; if (an !== 4'b1101) begin fails++; $display("FAIL mid_an got %b want 1101", an); end
    light = 8'b00_01_10_11;
    for (int k = 1; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        es = seg_of(old_l[2*k +: 2]);
        checks++; if (seg !== es) begin fails++; $display("FAIL mid_hold d%0d c%0d got %b want %b", k, c, seg, es); end
        cyc(1);
      end
    checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL mid_fd got %b want 1", frame_done); end
    checks++; if (seg !== 7'b1011000) begin fails++; $display("FAIL mid_new_d0 got %b want 1011000", seg); end
    cyc(4);
    checks++; if (seg !== 7'b0001000) begin fails++; $display("FAIL mid_new_d1 got %b want 0001000", seg); end
    light = 8'b11_10_01_00;
    blink_en = 4'b0100;
    cyc(12);
  endtask

  task automatic test_blink;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 4; k++) begin
        es = (k == 2 && (f == 2 || f == 3)) ? 7'b1111111 : seg_of(old_l[2*k +: 2]);
        ea = ~(4'b0001 << k);
        checks++; if (seg !== es) begin fails++; $display("FAIL blink_seg f%0d d%0d got %b want %b", f, k, seg, es); end
        checks++; if (an !== ea) begin fails++; $display("FAIL blink_an f%0d d%0d got %b want %b", f, k, an, ea); end
        cyc(4);
      end
  endtask

  task automatic test_reset_mid;
    cyc(8);
    checks++; if (an !== 4'b1011) begin fails++; $display("FAIL pre_rst_an got %b want 1011", an); end
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) begin fails++; $display("FAIL async_rst_an got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin fails++; $display("FAIL async_rst_seg got %b want 1111111", seg); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL async_rst_fd got %b want 0", frame_done); end
    checks++; if (an1 !== 1'b1) begin fails++; $display("FAIL async_rst_an1 got %b want 1", an1); end
    cyc(2);
    rst = 1'b0;
    cyc(3);
    checks++; if (an !== 4'b1111) begin fails++; $display("FAIL rerst_blank_an got %b want 1111", an); end
    cyc(1);
    checks++; if (an !== 4'b1110) begin fails++; $display("FAIL rerst_tick_an got %b want 1110", an); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rerst_tick_fd got %b want 0", frame_done); end
  endtask

  task automatic test_single;
    rst = 1'b1;
    light1 = 2'b10;
    cyc(1);
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc(1);
      checks++; if (an1 !== (n < 3)) begin fails++; $display("FAIL single_an n%0d got %b want %b", n, an1, n < 3); end
      checks++; if (fd1 !== (n >= 6 && n % 3 == 0)) begin fails++; $display("FAIL single_fd n%0d got %b", n, fd1); end
      es = n < 3 ? 7'b1111111 : n < 6 ? 7'b0000001 : 7'b0001000;
      checks++; if (seg1 !== es) begin fails++; $display("FAIL single_seg n%0d got %b want %b", n, seg1, es); end
    end
  endtask

  initial begin
    rst = 1'b1;
    light = '0;
    blink_en = '0;
    light1 = 2'b00;
    blink1 = 1'b0;
    cyc(2);
    test_reset;
    test_first_tick;
    test_scan;
    test_mid_frame;
    test_blink;
    test_reset_mid;
    test_single;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
